dmac_ahbl_regs: RTL and testbench

- AHB-Lite slave register file that configures and controls the DMA master engine.
- Holds the transfer descriptor (source/dest addresses, sizes, increments, block size/count, IRQ source, completion-write address/value).
- Issues a one-cycle start pulse and captures the engine's done pulse into a sticky status bit.
- Drives a level interrupt. Sits on the system AHB-Lite bus as a zero-wait-state responder next to the engine it configures.

---
 rtl/dmac_ahbl_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_dmac_ahbl_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ahbl_regs.sv
// ============================================================================
// dmac_ahbl_regs : AHB-Lite zero-wait register file for the DMA master engine
// Rev 1.0
// ============================================================================
`default_nettype none

module dmac_ahbl_regs (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [31:0] icra,
    output logic [31:0] icrv,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic [2:0]  irqsrc,
    output logic        wfi,
    output logic [7:0]  bsize,
    output logic [7:0]  bcount,
    output logic        start,
    input  logic        done,
    input  logic        busy,
    output logic        irq
);

    localparam logic [3:0] c_IDX_SADDR  = 4'd0;
    localparam logic [3:0] c_IDX_DADDR  = 4'd1;
    localparam logic [3:0] c_IDX_CFG    = 4'd2;
    localparam logic [3:0] c_IDX_COUNT  = 4'd3;
    localparam logic [3:0] c_IDX_ICRA   = 4'd4;
    localparam logic [3:0] c_IDX_ICRV   = 4'd5;
    localparam logic [3:0] c_IDX_CTRL   = 4'd6;
    localparam logic [3:0] c_IDX_STATUS = 4'd7;
    localparam logic [3:0] c_IDX_IE     = 4'd8;

    // Address-phase capture
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic [3:0]  idx_q, idx_d;

    // Descriptor and control state
    logic [31:0] saddr_q, saddr_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] icra_q, icra_d;
    logic [31:0] icrv_q, icrv_d;
    logic [2:0]  ssize_q, ssize_d;
    logic [2:0]  dsize_q, dsize_d;
    logic [2:0]  sinc_q, sinc_d;
    logic [2:0]  dinc_q, dinc_d;
    logic [2:0]  irqsrc_q, irqsrc_d;
    logic        wfi_q, wfi_d;
    logic [7:0]  bsize_q, bsize_d;
    logic [7:0]  bcount_q, bcount_d;
    logic        start_q, start_d;
    logic        done_flag_q, done_flag_d;
    logic        ie_q, ie_d;

    logic        w_commit;
    logic        w_desc_wr;
    logic        w_unused;

    assign w_unused  = ^{HADDR[31:6], HADDR[1:0], HSIZE, HTRANS[0]};

    assign w_commit  = wr_en_q & HREADY;
    // Descriptor fields are frozen while the engine is running
    assign w_desc_wr = w_commit & ~busy;

    always_comb begin
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        idx_d       = idx_q;
        saddr_d     = saddr_q;
        daddr_d     = daddr_q;
        icra_d      = icra_q;
        icrv_d      = icrv_q;
        ssize_d     = ssize_q;
        dsize_d     = dsize_q;
        sinc_d      = sinc_q;
        dinc_d      = dinc_q;
        irqsrc_d    = irqsrc_q;
        wfi_d       = wfi_q;
        bsize_d     = bsize_q;
        bcount_d    = bcount_q;
        start_d     = 1'b0;
        done_flag_d = done_flag_q;
        ie_d        = ie_q;

        if (HREADY) begin
            wr_en_d = HSEL & HTRANS[1] & HWRITE;
            rd_en_d = HSEL & HTRANS[1] & ~HWRITE;
            idx_d   = HADDR[5:2];
        end

        if (w_desc_wr) begin
            case (idx_q)
                c_IDX_SADDR: saddr_d = HWDATA;
                c_IDX_DADDR: daddr_d = HWDATA;
                c_IDX_CFG: begin
                    ssize_d  = HWDATA[2:0];
                    dsize_d  = HWDATA[6:4];
                    sinc_d   = HWDATA[10:8];
                    dinc_d   = HWDATA[14:12];
                    irqsrc_d = HWDATA[18:16];
                    wfi_d    = HWDATA[20];
                end
                c_IDX_COUNT: begin
                    bsize_d  = HWDATA[7:0];
                    bcount_d = HWDATA[15:8];
                end
                c_IDX_ICRA:  icra_d  = HWDATA;
                c_IDX_ICRV:  icrv_d  = HWDATA;
                c_IDX_CTRL:  start_d = HWDATA[0];
                default: ;
            endcase
        end

        if (w_commit && idx_q == c_IDX_IE) begin
            ie_d = HWDATA[0];
        end

        // A done pulse coinciding with a clear keeps the flag set
        if (w_commit && idx_q == c_IDX_STATUS && HWDATA[1]) begin
            done_flag_d = 1'b0;
        end
        if (done) begin
            done_flag_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            idx_q       <= 4'd0;
            saddr_q     <= 32'd0;
            daddr_q     <= 32'd0;
            icra_q      <= 32'd0;
            icrv_q      <= 32'd0;
            ssize_q     <= 3'd0;
            dsize_q     <= 3'd0;
            sinc_q      <= 3'd0;
            dinc_q      <= 3'd0;
            irqsrc_q    <= 3'd0;
            wfi_q       <= 1'b0;
            bsize_q     <= 8'd0;
            bcount_q    <= 8'd0;
            start_q     <= 1'b0;
            done_flag_q <= 1'b0;
            ie_q        <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            idx_q       <= idx_d;
            saddr_q     <= saddr_d;
            daddr_q     <= daddr_d;
            icra_q      <= icra_d;
            icrv_q      <= icrv_d;
            ssize_q     <= ssize_d;
            dsize_q     <= dsize_d;
            sinc_q      <= sinc_d;
            dinc_q      <= dinc_d;
            irqsrc_q    <= irqsrc_d;
            wfi_q       <= wfi_d;
            bsize_q     <= bsize_d;
            bcount_q    <= bcount_d;
            start_q     <= start_d;
            done_flag_q <= done_flag_d;
            ie_q        <= ie_d;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (rd_en_q) begin
            case (idx_q)
                c_IDX_SADDR:  HRDATA = saddr_q;
                c_IDX_DADDR:  HRDATA = daddr_q;
                c_IDX_CFG:    HRDATA = {11'd0, wfi_q, 1'b0, irqsrc_q, 1'b0, dinc_q,
                                        1'b0, sinc_q, 1'b0, dsize_q, 1'b0, ssize_q};
                c_IDX_COUNT:  HRDATA = {16'd0, bcount_q, bsize_q};
                c_IDX_ICRA:   HRDATA = icra_q;
                c_IDX_ICRV:   HRDATA = icrv_q;
                c_IDX_STATUS: HRDATA = {30'd0, done_flag_q, busy};
                c_IDX_IE:     HRDATA = {31'd0, ie_q};
                default:      HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign saddr     = saddr_q;
    assign daddr     = daddr_q;
    assign icra      = icra_q;
    assign icrv      = icrv_q;
    assign ssize     = ssize_q;
    assign dsize     = dsize_q;
    assign sinc      = sinc_q;
    assign dinc      = dinc_q;
    assign irqsrc    = irqsrc_q;
    assign wfi       = wfi_q;
    assign bsize     = bsize_q;
    assign bcount    = bcount_q;
    assign start     = start_q;
    assign irq       = done_flag_q & ie_q;

endmodule

`default_nettype wire

// File: tb/tb_dmac_ahbl_regs.sv
// ============================================================================
// tb_dmac_ahbl_regs : directed self-checking bench for dmac_ahbl_regs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmac_ahbl_regs;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] saddr, daddr, icra, icrv;
    logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic        wfi;
    logic [7:0]  bsize, bcount;
    logic        start;
    logic        done;
    logic        busy;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] rd;

    dmac_ahbl_regs u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .saddr     (saddr),
        .daddr     (daddr),
        .icra      (icra),
        .icrv      (icrv),
        .ssize     (ssize),
        .dsize     (dsize),
        .sinc      (sinc),
        .dinc      (dinc),
        .irqsrc    (irqsrc),
        .wfi       (wfi),
        .bsize     (bsize),
        .bcount    (bcount),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .irq       (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer: address phase, then data phase with the bus idle.
    // Returns at the data-phase negedge with HRDATA sampled; a write
    // commits at the following posedge.
    task automatic bus_xfer(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge HCLK);
        HSEL   = sel;
        HTRANS = trans;
        HADDR  = addr;
        HWRITE = wr;
        @(negedge HCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = wdata;
        rdata  = HRDATA;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_xfer(1'b1, 2'b10, addr, 1'b1, wdata, dummy);
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rdata);
        bus_xfer(1'b1, 2'b10, addr, 1'b0, 32'd0, rdata);
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = 32'd0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = 32'd0;
        HREADY  = 1'b1;
        done    = 1'b0;
        busy    = 1'b0;

        repeat (2) @(negedge HCLK);
        chk("rst_saddr", saddr, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        HRESETn = 1'b1;

        // Descriptor programming and read-back
        bus_wr(32'h00, 32'h2000_0000);
        bus_wr(32'h04, 32'h2000_1000);
        bus_wr(32'h08, 32'h0011_4422);
        bus_wr(32'h0C, 32'h0000_0310);
        bus_rd(32'h00, rd); chk("rd_saddr", rd, 32'h2000_0000);
        bus_rd(32'h04, rd); chk("rd_daddr", rd, 32'h2000_1000);
        bus_rd(32'h08, rd); chk("rd_cfg", rd, 32'h0011_4422);
        bus_rd(32'h0C, rd); chk("rd_count", rd, 32'h0000_0310);
        chk("ssize", {29'd0, ssize}, 32'd2);
        chk("dsize", {29'd0, dsize}, 32'd2);
        chk("sinc", {29'd0, sinc}, 32'd4);
        chk("dinc", {29'd0, dinc}, 32'd4);
        chk("irqsrc", {29'd0, irqsrc}, 32'd1);
        chk("wfi", {31'd0, wfi}, 32'd1);
        chk("bsize", {24'd0, bsize}, 32'h10);
        chk("bcount", {24'd0, bcount}, 32'h03);
        chk("daddr_out", daddr, 32'h2000_1000);

        // Start pulse
        bus_wr(32'h18, 32'h1);
        chk("start_pre", {31'd0, start}, 32'd0);
        @(negedge HCLK);
        chk("start_pulse", {31'd0, start}, 32'd1);
        @(negedge HCLK);
        chk("start_one_cycle", {31'd0, start}, 32'd0);
        bus_rd(32'h18, rd); chk("rd_ctrl", rd, 32'd0);

        // Busy blocks start and descriptor writes
        busy = 1'b1;
        bus_wr(32'h18, 32'h1);
        @(negedge HCLK);
        chk("start_busy", {31'd0, start}, 32'd0);
        bus_wr(32'h00, 32'hDEAD_BEEF);
        @(negedge HCLK);
        chk("start_busy2", {31'd0, start}, 32'd0);
        bus_rd(32'h00, rd); chk("saddr_protect", rd, 32'h2000_0000);
        bus_rd(32'h1C, rd); chk("status_busy", rd, 32'h1);
        busy = 1'b0;

        // done flag and interrupt
        bus_wr(32'h20, 32'h1);
        @(negedge HCLK);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        done = 1'b1;
        @(negedge HCLK);
        done = 1'b0;
        chk("irq_set", {31'd0, irq}, 32'd1);
        bus_rd(32'h1C, rd); chk("status_done", rd, 32'h2);
        bus_rd(32'h20, rd); chk("rd_ie", rd, 32'h1);
        bus_wr(32'h1C, 32'h2);
        @(negedge HCLK);
        chk("irq_clear", {31'd0, irq}, 32'd0);

        // done coinciding with the clearing data phase: set wins
        done = 1'b1;
        @(negedge HCLK);
        done = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1C; HWRITE = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h2;
        done = 1'b1;
        @(negedge HCLK);
        done = 1'b0;
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        bus_rd(32'h1C, rd); chk("set_wins_status", rd, 32'h2);

        // start does not clear done_flag
        bus_wr(32'h18, 32'h1);
        @(negedge HCLK);
        chk("start_again", {31'd0, start}, 32'd1);
        bus_rd(32'h1C, rd); chk("flag_after_start", rd, 32'h2);
        bus_wr(32'h1C, 32'h2);

        // Back-to-back write then read
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b1;
        @(negedge HCLK);
        HWDATA = 32'h5A5A_5A5A;
        HADDR  = 32'h14; HWRITE = 1'b0;
        chk("b2b_hreadyout1", {31'd0, HREADYOUT}, 32'd1);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("b2b_icrv", HRDATA, 32'h5A5A_5A5A);
        chk("b2b_hreadyout2", {31'd0, HREADYOUT}, 32'd1);
        chk("icrv_out", icrv, 32'h5A5A_5A5A);
        bus_wr(32'h10, 32'hC0DE_0010);
        bus_rd(32'h10, rd); chk("rd_icra", rd, 32'hC0DE_0010);

        // Unmapped, unselected and idle accesses
        bus_wr(32'h3C, 32'hFFFF_FFFF);
        bus_rd(32'h3C, rd); chk("rd_unmapped", rd, 32'd0);
        bus_xfer(1'b0, 2'b10, 32'h00, 1'b1, 32'h1234_5678, rd);
        bus_xfer(1'b1, 2'b00, 32'h00, 1'b1, 32'h8765_4321, rd);
        bus_xfer(1'b1, 2'b01, 32'h18, 1'b1, 32'h1, rd);
        @(negedge HCLK);
        chk("idle_no_start", {31'd0, start}, 32'd0);
        bus_rd(32'h00, rd); chk("saddr_unsel", rd, 32'h2000_0000);
        bus_xfer(1'b1, 2'b00, 32'h00, 1'b0, 32'd0, rd);
        chk("idle_rd_zero", rd, 32'd0);

        // Reset during a write data phase
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1111_1111;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_saddr", saddr, 32'd0);
        chk("rst_mid_icrv", icrv, 32'd0);
        chk("rst_mid_bcount", {24'd0, bcount}, 32'd0);
        chk("rst_mid_hrdata", HRDATA, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_no_start", {31'd0, start}, 32'd0);
        chk("rst_no_commit", saddr, 32'd0);
        bus_rd(32'h20, rd); chk("rst_ie", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
